seq_div_8: RTL and testbench

Multi-cycle unsigned 8-bit restoring divider, the inverse companion to the team's 8-bit ripple-carry adder datapath. It computes quotient and remainder by one shift-and-subtract step per clock. The subtract stage is a borrow-chain counterpart of the ripple adder. It sits beside the adder in the arithmetic cluster and uses a start/done handshake so control logic can issue a division and wait for the result.

---
 rtl/seq_div_8_pkg.sv | 14 +
 rtl/seq_div_8_sub_9.sv | 21 ++
 rtl/seq_div_8.sv | 114 +++++++++++
 tb/tb_seq_div_8.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_div_8_pkg.sv
// rtl/seq_div_8_pkg.sv - shared constants and state type for the restoring divider
package seq_div_8_pkg;

    localparam int DIV_W = 8;
    localparam logic [2:0] ITER_LAST = 3'd7;
    localparam logic [DIV_W-1:0] DIV0_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div_8_sub_9.sv
// rtl/seq_div_8_sub_9.sv - combinational 9-bit borrow-ripple subtractor
module sub_9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff,
    output logic       borrow
);

    logic [9:0] bw;

    assign bw[0] = 1'b0;

    // one full-subtractor cell per bit, borrow rippling toward the msb
    for (genvar i = 0; i < 9; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign borrow = bw[9];

endmodule

// File: rtl/seq_div_8.sv
// rtl/seq_div_8.sv - multi-cycle unsigned 8-bit restoring divider with start/done handshake
module seq_div_8
    import seq_div_8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] q_r;
    logic [DIV_W:0]   r_r;
    logic [DIV_W-1:0] d_r;
    logic [2:0]       iter;
    logic             dbz_r;

    logic [DIV_W:0]   t;
    logic [DIV_W:0]   diff;
    logic             borrow;
    logic             r_msb_unused;

    assign t = {r_r[DIV_W-1:0], q_r[DIV_W-1]};
    // the partial remainder never exceeds the divisor, so its top bit is never consumed
    assign r_msb_unused = r_r[DIV_W];

    sub_9 u_sub (
        .a      (t),
        .b      ({1'b0, d_r}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (iter == ITER_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
            iter  <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d_r  <= divisor;
                        iter <= '0;
                        if (divisor == '0) begin
                            dbz_r <= 1'b1;
                            q_r   <= DIV0_QUOT;
                            r_r   <= {1'b0, dividend};
                        end else begin
                            dbz_r <= 1'b0;
                            q_r   <= dividend;
                            r_r   <= '0;
                        end
                    end
                end
                CALC: begin
                    iter <= iter + 3'd1;
                    if (!borrow) begin
                        r_r <= diff;
                        q_r <= {q_r[DIV_W-2:0], 1'b1};
                    end else begin
                        r_r <= t;
                        q_r <= {q_r[DIV_W-2:0], 1'b0};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy        = (state == CALC);
        done        = (state == DONE);
        quotient    = q_r;
        remainder   = r_r[DIV_W-1:0];
        div_by_zero = dbz_r;
    end

endmodule

// File: tb/tb_seq_div_8.sv
// tb/tb_seq_div_8.sv - self-checking bench for seq_div_8 against an arithmetic reference
module tb_seq_div_8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks;
    int failures;

    seq_div_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
    // inject>0 pulses a 9/9 start during that busy cycle to prove it is ignored.
    task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int inject);
        int nbusy;
        int ncyc;
        int exp_q;
        int exp_r;
        bit got;
        exp_q = (b == 0) ? 255 : a / b;
        exp_r = (b == 0) ? a : a % b;
        start = 1'b1;
        dividend = a;
        divisor = b;
        nbusy = 0;
        ncyc = 0;
        got = 0;
        while (ncyc < 20) begin
            @(negedge clk);
            ncyc++;
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nbusy++;
            if (inject != 0 && nbusy == inject) begin
                start = 1'b1;
                dividend = 8'd9;
                divisor = 8'd9;
            end else begin
                start = 1'b0;
                dividend = 8'($urandom);
                divisor = 8'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, " done_seen"}, int'(got), 1);
        chk({tag, " latency"}, ncyc, (b == 0) ? 1 : 9);
        chk({tag, " busy_cycles"}, nbusy, (b == 0) ? 0 : 8);
        chk({tag, " quotient"}, int'(quotient), exp_q);
        chk({tag, " remainder"}, int'(remainder), exp_r);
        chk({tag, " div_by_zero"}, int'(div_by_zero), (b == 0) ? 1 : 0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, int'(done), 0);
        chk({tag, " quotient_held"}, int'(quotient), exp_q);
        chk({tag, " remainder_held"}, int'(remainder), exp_r);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " div_by_zero"}, int'(div_by_zero), 0);
        chk({tag, " quotient"}, int'(quotient), 0);
        chk({tag, " remainder"}, int'(remainder), 0);
    endtask

    initial begin
        int ndone;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_div("d200_7", 8'd200, 8'd7, 0);
        do_div("d255_1", 8'd255, 8'd1, 0);
        do_div("d255_255", 8'd255, 8'd255, 0);
        do_div("d5_9", 8'd5, 8'd9, 0);
        do_div("d0_3", 8'd0, 8'd3, 0);
        do_div("div0", 8'h5A, 8'd0, 0);
        do_div("after_div0", 8'd77, 8'd5, 0);

        do_div("ignore_start", 8'd100, 8'd3, 4);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignore_start extra_done", ndone, 0);

        // abandon a division mid-CALC with an asynchronous reset
        start = 1'b1;
        dividend = 8'd200;
        divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("post_reset idle", ndone, 0);
        do_div("d13_4", 8'd13, 8'd4, 0);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (i % 5 == 4) ? 8'd0 : 8'($urandom_range(1, 255));
            do_div("random", ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
